// File: rtl/mult_if.sv
// mult_if: strobe, operand and result bundle between the multiplier controller and datapath
interface mult_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               sig_rst;
    logic               ld1;
    logic               ld2;
    logic               s0;
    logic               s1;
    logic               s2;
    logic               cnt_done;
    logic [2*WIDTH-1:0] product;
    logic               p_valid;

    modport master (
        output a_in, b_in, sig_rst, ld1, ld2, s0, s1, s2,
        input  cnt_done, product, p_valid
    );

    modport slave (
        input  a_in, b_in, sig_rst, ld1, ld2, s0, s1, s2,
        output cnt_done, product, p_valid
    );
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: shift-add datapath executing the multiplier controller's strobes
module mult_datapath #(
    parameter int WIDTH = 4
) (
    input logic   clk,
    input logic   rst,
    mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               p_valid_q, p_valid_d;
    logic [WIDTH:0]     sum;
    logic               done;
    logic               shift_ok;

    assign done         = cnt_q == CW'(WIDTH);
    assign bus.cnt_done = done;
    assign bus.product  = product_q;
    assign bus.p_valid  = p_valid_q;

    // Next state: add feeds the shift in the same cycle; sig_rst wins on acc/cnt, ld2 wins on Q
    always_comb begin
        sum       = acc_q + ((bus.s0 && q_q[0]) ? {1'b0, a_q} : '0);
        shift_ok  = bus.s1 && !done;
        a_d       = bus.ld1 ? bus.a_in : a_q;
        q_d       = bus.ld2 ? bus.b_in : shift_ok ? {sum[0], q_q[WIDTH-1:1]} : q_q;
        acc_d     = bus.sig_rst ? '0 : shift_ok ? {1'b0, sum[WIDTH:1]} : sum;
        cnt_d     = bus.sig_rst ? '0 : shift_ok ? cnt_q + 1'b1 : cnt_q;
        product_d = bus.s2 ? {acc_q[WIDTH-1:0], q_q} : product_q;
        p_valid_d = bus.s2;
    end

    // State registers with synchronous reset overriding every strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            p_valid_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            p_valid_q <= p_valid_d;
        end
    end
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed scoreboard bench for the shift-add multiplier datapath
module tb_mult_datapath;
    localparam logic [5:0] SR = 6'b100000, L1 = 6'b010000, L2 = 6'b001000,
                           S0 = 6'b000100, S1 = 6'b000010, S2 = 6'b000001, ID = 6'b000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   exp_q[$];

    mult_if #(.WIDTH(4)) bus ();
    mult_datapath #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input logic [5:0] st);
        {bus.sig_rst, bus.ld1, bus.ld2, bus.s0, bus.s1, bus.s2} = st;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b);
        bus.a_in = a;
        bus.b_in = b;
        cyc(SR | L1 | L2);
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input bit split);
        load(a, b);
        for (int i = 0; i < 4; i++) begin
            check("cnt_done_low", int'(bus.cnt_done), 0);
            if (split) begin
                cyc(S0);
                cyc(S1);
            end else cyc(S0 | S1);
        end
        check("cnt_done_high", int'(bus.cnt_done), 1);
    endtask

    task automatic latch(input int exp);
        exp_q.push_back(exp);
        cyc(S2);
        cyc(ID);
    endtask

    // Monitor: every p_valid cycle must match the oldest pending expectation
    initial forever begin
        @(negedge clk);
        if (bus.p_valid) begin
            if (exp_q.size() == 0) check("p_valid_unexpected", int'(bus.p_valid), 0);
            else check("product", int'(bus.product), exp_q.pop_front());
        end
    end

    initial begin
        bus.a_in = '0;
        bus.b_in = '0;
        cyc(ID);
        cyc(ID);
        check("rst_product", int'(bus.product), 0);
        check("rst_p_valid", int'(bus.p_valid), 0);
        check("rst_cnt_done", int'(bus.cnt_done), 0);
        rst = 1'b0;
        cyc(ID);

        run(4'd15, 4'd15, 1'b0);
        exp_q.push_back(225);
        cyc(S2);
        latch(225);
        check("p_valid_single", int'(bus.p_valid), 0);

        run(4'd13, 4'd11, 1'b0); latch(143);
        run(4'd0, 4'd9, 1'b0);   latch(0);
        run(4'd9, 4'd0, 1'b0);   latch(0);

        run(4'd7, 4'd6, 1'b0);
        cyc(S1);
        check("cnt_done_hold", int'(bus.cnt_done), 1);
        latch(42);

        load(4'd15, 4'd15);
        cyc(S0 | S1);
        cyc(S0 | S1);
        cyc(SR);
        check("sig_rst_cnt_done", int'(bus.cnt_done), 0);
        latch(7);
        check("sig_rst_keeps_product", int'(bus.product), 7);
        run(4'd3, 4'd5, 1'b0);   latch(15);

        load(4'd15, 4'd15);
        cyc(S0 | S1);
        cyc(S0 | S1);
        rst = 1'b1;
        cyc(ID);
        check("mid_rst_product", int'(bus.product), 0);
        check("mid_rst_p_valid", int'(bus.p_valid), 0);
        check("mid_rst_cnt_done", int'(bus.cnt_done), 0);
        rst = 1'b0;
        run(4'd6, 4'd7, 1'b0);   latch(42);

        run(4'd11, 4'd5, 1'b1);  latch(55);
        run(4'd11, 4'd5, 1'b0);  latch(55);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(ID);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
